pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter WIDTH, default 32, program-counter width in bits.
REQ-002 Parameter RESET_VEC, default 0, pc_o value after reset and in IDLE.
REQ-003 Parameter INC, default 4, sequential fetch stride in bytes; a power of two.
REQ-004 Parameter EXC_VEC, default 32'h80, exception target; used only when PC_SEQ_EXC_EN is defined.
REQ-005 Port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port rst_i, input, 1, reset; asynchronous and active-low.
REQ-007 Port start_i, input, 1, level; leaves IDLE while high.
REQ-008 Port halt_i, input, 1, pulse; enters HALT.
REQ-009 Port stall_i, input, 1, hold pc_o, the PCWrite-style freeze.
REQ-010 Port redirect_i, input, 1, load redirect_pc_i (branch/jump).
REQ-011 Port redirect_pc_i, input, WIDTH, redirect target.
REQ-012 Port ready_i, input, 1, fetch consumer accepts pc_o this cycle.
REQ-013 Port exc_i, input, 1, exception request; present only with PC_SEQ_EXC_EN.
REQ-014 Port pc_o, output, WIDTH, current fetch address.
REQ-015 Port valid_o, output, 1, pc_o is a live fetch request.
REQ-016 Port misalign_o, output, 1, registered flag: last redirect target had nonzero bits below log2(INC).
REQ-017 Port epc_o, output, WIDTH, pc_o at the exception; present only with PC_SEQ_EXC_EN.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and HALT.
- IDLE -> RUN when start_i=1.
- RUN -> HALT when halt_i=1.
- HALT -> IDLE when start_i=0; HALT is exited only through IDLE.
REQ-019 valid_o SHALL be 1 only in RUN and SHALL be combinational from state.
REQ-020 In IDLE and HALT, pc_o SHALL hold its value and all pc inputs SHALL be ignored, except that IDLE entry from HALT reloads RESET_VEC.
REQ-021 In RUN, next pc SHALL be chosen by strict priority: exc_i > redirect_i > stall_i (hold) > ready_i (pc_o+INC) > hold.
REQ-022 A redirect SHALL take effect in one cycle: pc_o = redirect_pc_i with the low log2(INC) bits cleared, on the edge where redirect_i=1.
- misalign_o SHALL be set if any cleared bit was 1.
- misalign_o SHALL be cleared on the next accepted redirect with aligned bits, or on reset.
REQ-023 Redirect SHALL override stall_i in the same cycle, so the pipeline can flush while frozen.
REQ-024 Increment SHALL wrap modulo 2^WIDTH: pc_o of all-ones-aligned plus INC gives 0, with no flag.
REQ-025 halt_i coincident with redirect_i in RUN SHALL apply the redirect and enter HALT on the same edge.
REQ-026 start_i in RUN SHALL be ignored.

Reset
REQ-027 On rst_i=0, regardless of clk_i, the block SHALL set state=IDLE, pc_o=RESET_VEC, misalign_o=0 and epc_o=0.
REQ-028 Reset asserted mid-redirect or mid-stall SHALL discard the pending update; the first post-reset edge SHALL obey IDLE rules.

Configuration
REQ-029 The macro PC_SEQ_EXC_EN SHALL control the exception feature.
- Defined: exc_i in RUN loads pc_o=EXC_VEC and epc_o=the pre-edge pc_o in one cycle, with top priority.
- Undefined: the exc_i and epc_o ports are absent and no exception logic is generated.

Structure
REQ-030 Package pc_seq_pkg SHALL hold the state enum (IDLE, RUN, HALT) and the next-pc select encoding (SEL_EXC, SEL_REDIR, SEL_HOLD, SEL_INC).
REQ-031 A combinational sub-module pc_seq_next SHALL implement the priority select and alignment masking; pc_seq SHALL hold the FSM and registers.

Verification
REQ-032 Reset then start_i=1, ready_i=1 for 3 cycles (INC=4) -> pc_o = 0, 4, 8, 12 with valid_o=1 from the first RUN cycle.
REQ-033 In RUN at pc=0x10, stall_i=1 and redirect_i=1 with redirect_pc_i=0x103 -> next pc_o=0x100, misalign_o=1; then stall_i alone -> pc_o holds 0x100.
REQ-034 WIDTH=8, pc_o=0xFC, ready_i=1 -> pc_o=0x00, misalign_o unchanged.
REQ-035 halt_i pulse at pc=0x20 -> HALT with valid_o=0 and pc_o=0x20 held; start_i=0 then 1 -> IDLE with pc_o=RESET_VEC, then RUN.
REQ-036 With PC_SEQ_EXC_EN: exc_i=1 and redirect_i=1 at pc=0x44 -> pc_o=0x80, epc_o=0x44; rst_i pulled low between clock edges -> pc_o=RESET_VEC immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states and next-pc select codes.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_EXC   = 2'd0,
    SEL_REDIR = 2'd1,
    SEL_HOLD  = 2'd2,
    SEL_INC   = 2'd3
  } sel_t;

endpackage

// File: rtl/pc_seq_next.sv
// Combinational next-pc select: exc > redirect > stall > ready > hold, with redirect alignment.
// Exception path is present only when PC_SEQ_EXC_EN is defined.
module pc_seq_next
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               INC     = 4,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(32'h80)
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  input  logic             ready,
`ifdef PC_SEQ_EXC_EN
  input  logic             exc,
`endif
  output logic [WIDTH-1:0] next_pc,
  output sel_t             sel,
  output logic             redir_misalign
);

  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INC - 1);

  assign redir_misalign = |(redirect_pc & LOW_MASK);

  // Lowest priority first; each later test overrides the earlier ones.
  always_comb begin
    sel     = SEL_HOLD;
    next_pc = pc;
    if (ready) begin
      sel     = SEL_INC;
      next_pc = pc + WIDTH'(INC);
    end
    if (stall) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end
    if (redirect) begin
      sel     = SEL_REDIR;
      next_pc = redirect_pc & ~LOW_MASK;
    end
`ifdef PC_SEQ_EXC_EN
    if (exc) begin
      sel     = SEL_EXC;
      next_pc = EXC_VEC;
    end
`endif
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: IDLE/RUN/HALT FSM plus pc, misalign and (optional) epc registers.
// Define PC_SEQ_EXC_EN to add the exc_i/epc_o exception path.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               INC       = 4,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h80)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic             ready_i,
`ifdef PC_SEQ_EXC_EN
  input  logic             exc_i,
  output logic [WIDTH-1:0] epc_o,
`endif
  output logic [WIDTH-1:0] pc_o,
  output logic             valid_o,
  output logic             misalign_o
);

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] next_pc;
  sel_t             sel;
  logic             redir_misalign;

  pc_seq_next #(
    .WIDTH  (WIDTH),
    .INC    (INC),
    .EXC_VEC(EXC_VEC)
  ) u_next (
    .pc            (pc_o),
    .redirect      (redirect_i),
    .redirect_pc   (redirect_pc_i),
    .stall         (stall_i),
    .ready         (ready_i),
`ifdef PC_SEQ_EXC_EN
    .exc           (exc_i),
`endif
    .next_pc       (next_pc),
    .sel           (sel),
    .redir_misalign(redir_misalign)
  );

`ifndef PC_SEQ_EXC_EN
  logic unused_exc_vec;
  assign unused_exc_vec = ^EXC_VEC;
`endif

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (start_i)  state_nx = RUN;
      RUN:     if (halt_i)   state_nx = HALT;
      HALT:    if (!start_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign valid_o = (state_q == RUN);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      pc_o       <= RESET_VEC;
      misalign_o <= 1'b0;
`ifdef PC_SEQ_EXC_EN
      epc_o      <= '0;
`endif
    end else begin
      state_q <= state_nx;
      case (state_q)
        RUN: begin
          pc_o <= next_pc;
          if (sel == SEL_REDIR) misalign_o <= redir_misalign;
`ifdef PC_SEQ_EXC_EN
          if (sel == SEL_EXC) epc_o <= pc_o;
`endif
        end
        // Leaving HALT always restarts fetch from the reset vector.
        HALT: if (!start_i) pc_o <= RESET_VEC;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: a 32-bit instance for the main flows and an 8-bit one for wrap.
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, halt, stall, redir, ready, exc;
  logic [31:0] rpc, pc, epc;
  logic        valid, mis;
  logic        start8, redir8, ready8, exc8;
  logic [7:0]  rpc8, pc8, epc8;
  logic        valid8, mis8;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pc_seq u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .halt_i       (halt),
    .stall_i      (stall),
    .redirect_i   (redir),
    .redirect_pc_i(rpc),
    .ready_i      (ready),
`ifdef PC_SEQ_EXC_EN
    .exc_i        (exc),
    .epc_o        (epc),
`endif
    .pc_o         (pc),
    .valid_o      (valid),
    .misalign_o   (mis)
  );

  pc_seq #(.WIDTH(8), .RESET_VEC(8'h00), .INC(4), .EXC_VEC(8'h80)) u_dut8 (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start8),
    .halt_i       (1'b0),
    .stall_i      (1'b0),
    .redirect_i   (redir8),
    .redirect_pc_i(rpc8),
    .ready_i      (ready8),
`ifdef PC_SEQ_EXC_EN
    .exc_i        (exc8),
    .epc_o        (epc8),
`endif
    .pc_o         (pc8),
    .valid_o      (valid8),
    .misalign_o   (mis8)
  );

`ifndef PC_SEQ_EXC_EN
  assign epc  = '0;
  assign epc8 = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    {start, halt, stall, redir, ready, exc} = '0;
    rpc = '0;
    {start8, redir8, ready8, exc8} = '0;
    rpc8 = '0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_mis", 32'(mis), 32'd0);
    chk("rst_pc8", 32'(pc8), 32'h0);
    rst = 1'b1;

    // 8-bit wrap: misaligned redirect to 0xFD lands on 0xFC, then +4 wraps to 0
    start8 = 1'b1;
    step();
    chk("w8_run_pc", 32'(pc8), 32'h0);
    chk("w8_valid", 32'(valid8), 32'd1);
    redir8 = 1'b1; rpc8 = 8'hFD;
    step();
    chk("w8_redir_pc", 32'(pc8), 32'hFC);
    chk("w8_redir_mis", 32'(mis8), 32'd1);
    redir8 = 1'b0; ready8 = 1'b1;
    step();
    chk("w8_wrap_pc", 32'(pc8), 32'h00);
    chk("w8_wrap_mis", 32'(mis8), 32'd1);
    ready8 = 1'b0; start8 = 1'b0;

    // Sequential fetch from reset vector
    start = 1'b1; ready = 1'b1;
    step();
    chk("seq_pc0", pc, 32'h0);
    chk("seq_valid", 32'(valid), 32'd1);
    step(); chk("seq_pc4", pc, 32'h4);
    step(); chk("seq_pc8", pc, 32'h8);
    step(); chk("seq_pc12", pc, 32'hC);
    step(); chk("seq_pc16", pc, 32'h10);

    // Redirect overrides stall; then stall alone holds
    stall = 1'b1; redir = 1'b1; rpc = 32'h103;
    step();
    chk("flush_pc", pc, 32'h100);
    chk("flush_mis", 32'(mis), 32'd1);
    redir = 1'b0;
    step();
    chk("stall_pc", pc, 32'h100);
    chk("stall_mis", 32'(mis), 32'd1);
    stall = 1'b0; redir = 1'b1; rpc = 32'h20;
    step();
    chk("align_pc", pc, 32'h20);
    chk("align_mis", 32'(mis), 32'd0);

    // Halt, inputs ignored in HALT, exit through IDLE
    redir = 1'b0; ready = 1'b0; halt = 1'b1;
    step();
    chk("halt_pc", pc, 32'h20);
    chk("halt_valid", 32'(valid), 32'd0);
    halt = 1'b0; ready = 1'b1; redir = 1'b1; rpc = 32'h203;
    step();
    chk("halt_hold_pc", pc, 32'h20);
    chk("halt_hold_mis", 32'(mis), 32'd0);
    redir = 1'b0; start = 1'b0;
    step();
    chk("idle_pc", pc, 32'h0);
    chk("idle_valid", 32'(valid), 32'd0);
    step();
    chk("idle_hold_pc", pc, 32'h0);
    start = 1'b1;
    step();
    chk("rerun_pc", pc, 32'h0);
    chk("rerun_valid", 32'(valid), 32'd1);
    step();
    chk("rerun_inc", pc, 32'h4);

    // Halt together with redirect: redirect applied, HALT entered
    redir = 1'b1; rpc = 32'h44; halt = 1'b1;
    step();
    chk("hr_pc", pc, 32'h44);
    chk("hr_valid", 32'(valid), 32'd0);
    redir = 1'b0; halt = 1'b0; start = 1'b0;
    step();
    chk("hr_idle_pc", pc, 32'h0);
    start = 1'b1;
    step();
    redir = 1'b1; rpc = 32'h44;
    step();
    chk("pre_exc_pc", pc, 32'h44);

`ifdef PC_SEQ_EXC_EN
    exc = 1'b1; rpc = 32'h300;
    step();
    chk("exc_pc", pc, 32'h80);
    chk("exc_epc", epc, 32'h44);
    exc = 1'b0;
`endif

    // Asynchronous reset while stalled, between clock edges
    redir = 1'b0; stall = 1'b1;
    #4 rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_mis", 32'(mis), 32'd0);
    chk("arst_epc", epc, 32'h0);
    start = 1'b0;
    #1 rst = 1'b1;
    step();
    chk("post_rst_pc", pc, 32'h0);
    chk("post_rst_valid", 32'(valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
